// File: rtl/phy_pkg.sv
// phy_pkg: shared PHY constants and the serializer FSM state encoding.
package phy_pkg;
  localparam logic [7:0] COM_DEFAULT = 8'hBC;
  typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, DATA = 2'd2} state_e;
endpackage

// File: rtl/par_serial.sv
// par_serial: MSB-first byte serializer with a COM-symbol sync preamble and comma idle fill.
module par_serial
  import phy_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] COM_SYMBOL = DATA_W'(COM_DEFAULT),
  parameter int                SYNC_MIN   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              serial_out,
  output logic              frame_sync,
  output logic              k_out
);
  localparam int CW = $clog2(DATA_W);
  localparam int SW = $clog2(SYNC_MIN + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  localparam logic [SW-1:0] SMAX = SW'(SYNC_MIN);
  state_e            state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]     sync_cnt_q, sync_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              active, last, take;
  assign active     = state_q != IDLE;
  assign last       = bit_cnt_q == LAST;
  assign ready_out  = active && last && sync_cnt_q == SMAX;
  assign take       = ready_out && valid_in;
  assign frame_sync = active && bit_cnt_q == '0;
  assign k_out      = state_q == SYNC;
  assign serial_out = shreg_q[DATA_W-1];
  // A COM counts as complete once its final bit is on the line, so ready_out
  // can open on that last bit and data follows the preamble without a gap.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = active ? (last ? '0 : bit_cnt_q + CW'(1)) : '0;
    sync_cnt_d = (state_q == SYNC && bit_cnt_q == LAST - CW'(1) && sync_cnt_q != SMAX)
                 ? sync_cnt_q + SW'(1) : sync_cnt_q;
    shreg_d    = {shreg_q[DATA_W-2:0], 1'b0};
    if (!active) begin
      state_d = SYNC;
      shreg_d = COM_SYMBOL;
    end else if (last) begin
      state_d = take ? DATA : SYNC;
      shreg_d = take ? data_in : COM_SYMBOL;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      sync_cnt_q <= '0;
      shreg_q    <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sync_cnt_q <= sync_cnt_d;
      shreg_q    <= shreg_d;
    end
  end
endmodule

// File: doc/par_serial.md
PAR_SERIAL -- requirements
Module: par_serial

Interface
REQ-001 Parameter DATA_W, default 8, width of the parallel byte path.
REQ-002 Parameter COM_SYMBOL, default 8'hBC, the comma/idle symbol sent when no data is offered.
REQ-003 Parameter SYNC_MIN, default 2, number of complete COM symbols sent after reset before data is accepted.
REQ-004 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port data_in  input  DATA_W  parallel byte from the upstream 4:1 lane mux.
REQ-007 Port valid_in  input  1  data_in holds a byte to transmit.
REQ-008 Port ready_out  output  1  block captures data_in this cycle if valid_in is high.
REQ-009 Port serial_out  output  1  registered serial bit stream, MSB first.
REQ-010 Port frame_sync  output  1  high while serial_out carries bit 7 (the first bit) of a symbol.
REQ-011 Port k_out  output  1  high for every bit of a COM symbol, low for every bit of a data symbol.

Function
REQ-012 FSM states: IDLE, SYNC, DATA.
REQ-013 IDLE lasts exactly one cycle after reset release, then goes to SYNC; serial_out, frame_sync and k_out are 0 in IDLE.
REQ-014 bit_cnt is 3 bits, 0..7, and increments every cycle in SYNC and DATA; it wraps 7->0 at each symbol boundary.
REQ-015 In SYNC, COM_SYMBOL is loaded at each boundary, k_out=1, and sync_cnt counts completed COMs, saturating at SYNC_MIN.
REQ-016 ready_out = 1 only when bit_cnt==7 and sync_cnt==SYNC_MIN (state SYNC or DATA); it is combinational from state.
REQ-017 Capture: when ready_out && valid_in, the shift register loads data_in; the FSM enters or stays in DATA; bit 7 appears on serial_out the next cycle.
REQ-018 Boundary with valid_in low (in DATA or eligible SYNC): COM_SYMBOL is loaded instead and the FSM goes to or stays in SYNC; data never stalls mid-symbol.
REQ-019 Back-to-back accepted bytes are serialized with no gap bits: 8 bits per byte, continuous.
REQ-020 valid_in asserted while ready_out is low is ignored; data_in is not sampled.
REQ-021 frame_sync = 1 exactly when bit_cnt==0 in SYNC or DATA; one pulse per 8 cycles.
REQ-022 The shift register shifts left one bit per cycle; serial_out is the registered MSB.

Reset
REQ-023 Asserting reset at any time, including mid-symbol, immediately clears state (IDLE), bit_cnt=0, sync_cnt=0, shift register=0, serial_out=0, frame_sync=0, k_out=0, ready_out=0.
REQ-024 A partially sent symbol is abandoned on reset and is not resumed; after release the SYNC_MIN COM preamble repeats in full.

Structure
REQ-025 The shared package phy_pkg holds COM_SYMBOL's default value (8'hBC) and the FSM state encoding (IDLE=2'd0, SYNC=2'd1, DATA=2'd2).
REQ-026 Single flat module; no sub-module is required (the counter and shifter are inline).
REQ-027 Target size is 120-400 RTL lines; there are no latches and no combinational paths from data_in to outputs.

Verification
REQ-028 Reset, then hold valid_in=0 for 40 cycles -> 1 idle cycle of 0, then repeating 10111100, with k_out=1 throughout and frame_sync every 8th cycle.
REQ-029 After 2 COMs, valid_in=1, data_in=8'hF0 at ready_out -> next 8 bits 11110000, with k_out=0 on those bits and COM resuming afterwards.
REQ-030 Hold valid_in=1 through two boundaries, with 8'hFF then 8'h0F -> 16 contiguous bits 1111111100001111, with no COM between them.
REQ-031 valid_in=1, data_in=8'h00 during the first COM (sync_cnt<2) -> ready_out stays 0, and the byte is not sent until after the second COM.
REQ-032 Assert reset at bit 3 of a data byte 8'hFF -> all outputs 0 in the same cycle; after release 1 IDLE cycle, then 2 full COMs before ready_out.
